debouncer_bank: RTL and testbench

Multi-channel, parametrised push-button/switch debouncer for the board-input front end, feeding the BCD counter control logic. Each channel synchronises an asynchronous mechanical input into the system clock and qualifies level changes with a programmable stability count. Each channel then produces a clean level, single-cycle rise/fall pulses and, optionally, a press-toggled output. It replaces per-button ad-hoc debouncing with one clocked, resettable block.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/debounce_ch.sv | 102 ++++++++++
 rtl/debouncer_bank.sv | 43 ++++
 tb/tb_debouncer_bank.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and elaboration helpers for the debouncer bank.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } deb_state_e;

  // True when a cnt_w-bit counter can reach stable_cnt-1.
  function automatic bit cnt_fits(int cnt_w, int stable_cnt);
    longint max_cnt;
    max_cnt = (longint'(1) << cnt_w) - 1;
    return max_cnt >= longint'(stable_cnt - 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, qualification FSM with stability counter,
// registered level/toggle output and single-cycle rise/fall pulses.
module debounce_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 50000,
  parameter int CNT_W       = 16,
  parameter int TOGGLE_MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sen_in,
  output logic sen_out,
  output logic rise,
  output logic fall
);
  import debounce_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_e             state_q, state_nxt;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt;
  logic                   rise_nxt, fall_nxt, out_nxt;

  // Synchroniser stage: sen_in is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], sen_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A reverting input wins over tick; the entry cycle into CHK_* is not counted.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state_q)
      ST_LO: begin
        if (s) begin
          state_nxt = CHK_HI;
          cnt_nxt   = '0;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_nxt = ST_LO;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_nxt = ST_HI;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HI: begin
        if (!s) begin
          state_nxt = CHK_LO;
          cnt_nxt   = '0;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_nxt = ST_HI;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_nxt = ST_LO;
            fall_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_nxt = ST_LO;
    endcase

    if (TOGGLE_MODE != 0) out_nxt = sen_out ^ rise_nxt;
    else                  out_nxt = (state_nxt == ST_HI) || (state_nxt == CHK_LO);
  end

  // Output register stage: every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      sen_out <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      sen_out <= out_nxt;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
    end
  end

endmodule

// File: rtl/debouncer_bank.sv
// Bank of N_CH independent debounce channels sharing clock, reset and tick.
module debouncer_bank #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 50000,
  parameter int CNT_W       = 16,
  parameter int TOGGLE_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [N_CH-1:0] sen_in,
  output logic [N_CH-1:0] sen_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);
  import debounce_pkg::*;

  if (!cnt_fits(CNT_W, STABLE_CNT)) begin : g_cnt_w_chk
    $error("debouncer_bank: CNT_W too narrow for STABLE_CNT");
  end
  if (SYNC_STAGES < 2 || STABLE_CNT < 1 || N_CH < 1) begin : g_param_chk
    $error("debouncer_bank: SYNC_STAGES>=2, STABLE_CNT>=1, N_CH>=1 required");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_CNT  (STABLE_CNT),
      .CNT_W       (CNT_W),
      .TOGGLE_MODE (TOGGLE_MODE)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .sen_in  (sen_in[i]),
      .sen_out (sen_out[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

endmodule

// File: tb/tb_debouncer_bank.sv
// Self-checking bench for debouncer_bank: level and toggle instances against a
// behavioural qualification model, plus directed latency checks.
module tb_debouncer_bank;
  localparam int N_CH   = 4;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int CNT_W  = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            tick;
  logic [N_CH-1:0] sen_in;
  logic [N_CH-1:0] sen_out, rise, fall;
  logic [N_CH-1:0] sen_out_t, rise_t, fall_t;

  always #5 clk = ~clk;

  debouncer_bank #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .STABLE_CNT(STABLE),
                   .CNT_W(CNT_W), .TOGGLE_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .sen_in(sen_in),
    .sen_out(sen_out), .rise(rise), .fall(fall));

  debouncer_bank #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .STABLE_CNT(STABLE),
                   .CNT_W(CNT_W), .TOGGLE_MODE(1)) dut_t (
    .clk(clk), .rst_n(rst_n), .tick(tick), .sen_in(sen_in),
    .sen_out(sen_out_t), .rise(rise_t), .fall(fall_t));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: input delayed SYNC samples; a differing level must persist for
  // STABLE ticks counted after the cycle in which the difference is first seen.
  logic [N_CH-1:0] m_d [SYNC];
  logic [N_CH-1:0] m_level, m_pend, m_rise, m_fall, m_tog;
  int              m_ticks [N_CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC; k++) m_d[k] <= '0;
      m_level <= '0; m_pend <= '0; m_rise <= '0; m_fall <= '0; m_tog <= '0;
      for (int c = 0; c < N_CH; c++) m_ticks[c] <= 0;
    end else begin
      m_d[0] <= sen_in;
      for (int k = 1; k < SYNC; k++) m_d[k] <= m_d[k-1];
      m_rise <= '0;
      m_fall <= '0;
      for (int c = 0; c < N_CH; c++) begin
        if (m_d[SYNC-1][c] == m_level[c]) begin
          m_pend[c] <= 1'b0;
        end else if (!m_pend[c]) begin
          m_pend[c]  <= 1'b1;
          m_ticks[c] <= 0;
        end else if (tick) begin
          if (m_ticks[c] + 1 == STABLE) begin
            m_level[c] <= ~m_level[c];
            m_pend[c]  <= 1'b0;
            if (!m_level[c]) begin
              m_rise[c] <= 1'b1;
              m_tog[c]  <= ~m_tog[c];
            end else begin
              m_fall[c] <= 1'b1;
            end
          end else begin
            m_ticks[c] <= m_ticks[c] + 1;
          end
        end
      end
    end
  end

  logic [6*N_CH-1:0] act, exp_v;
  assign act   = {sen_out, rise, fall, sen_out_t, rise_t, fall_t};
  assign exp_v = {m_level, m_rise, m_fall, m_tog, m_rise, m_fall};

  task automatic test_reset();
    rst_n = 1'b0; sen_in = '0; tick = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (act !== '0) $display("FAIL reset_state: got %h want 0", act);
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (act !== '0) $display("FAIL reset_idle: got %h want 0", act);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    logic [N_CH-1:0] e_r, e_o;
    sen_in[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      e_r = (k == 7) ? 4'b0001 : 4'b0000;
      e_o = (k >= 7) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (act !== exp_v) $display("FAIL press_model edge %0d: got %h want %h", k, act, exp_v);
      else n_pass++;
      n_checks++;
      if ({rise, sen_out, fall} !== {e_r, e_o, 4'b0000})
        $display("FAIL press_latency edge %0d: got %h want %h", k, {rise, sen_out, fall}, {e_r, e_o, 4'b0000});
      else n_pass++;
    end
    sen_in[0] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 16; i++) begin
      sen_in[1] = (i < 3) || (i >= 5 && i < 8);
      @(negedge clk);
      n_checks++;
      if (act !== exp_v) $display("FAIL bounce_model cyc %0d: got %h want %h", i, act, exp_v);
      else n_pass++;
      n_checks++;
      if ({rise[1], sen_out[1]} !== 2'b00)
        $display("FAIL bounce_reject cyc %0d: got %b want 00", i, {rise[1], sen_out[1]});
      else n_pass++;
    end
  endtask

  task automatic test_release();
    sen_in[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (act !== exp_v) $display("FAIL release_model edge %0d: got %h want %h", k, act, exp_v);
      else n_pass++;
      n_checks++;
      if ({rise[2], fall[2], sen_out[2]} !== {k == 7, k == 17, k >= 7 && k < 17})
        $display("FAIL release_timing edge %0d: got %b want %b", k,
                 {rise[2], fall[2], sen_out[2]}, {k == 7, k == 17, k >= 7 && k < 17});
      else n_pass++;
      if (k == 10) sen_in[2] = 1'b0;
    end
  endtask

  task automatic test_toggle();
    int n_rise = 0;
    int n_fall = 0;
    for (int cyc = 0; cyc < 58; cyc++) begin
      sen_in[3] = (cyc < 48) && ((cyc % 16) < 8);
      @(negedge clk);
      n_checks++;
      if (act !== exp_v) $display("FAIL toggle_model cyc %0d: got %h want %h", cyc, act, exp_v);
      else n_pass++;
      if (rise_t[3]) begin
        n_rise++;
        n_checks++;
        if (sen_out_t[3] !== n_rise[0])
          $display("FAIL toggle_state rise %0d: got %b want %b", n_rise, sen_out_t[3], n_rise[0]);
        else n_pass++;
      end
      if (fall_t[3]) n_fall++;
    end
    n_checks++;
    if ({n_rise, n_fall} !== {32'd3, 32'd3})
      $display("FAIL toggle_pulses: got rise %0d fall %0d want 3 3", n_rise, n_fall);
    else n_pass++;
    n_checks++;
    if ({sen_out_t[3], sen_out[3]} !== 2'b10)
      $display("FAIL toggle_final: got %b want 10", {sen_out_t[3], sen_out[3]});
    else n_pass++;
  endtask

  task automatic test_sparse_tick();
    sen_in[0] = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      tick = (cyc % 4 == 3);
      @(negedge clk);
      n_checks++;
      if (act !== exp_v) $display("FAIL sparse_model edge %0d: got %h want %h", cyc + 1, act, exp_v);
      else n_pass++;
      n_checks++;
      if ({rise[0], sen_out[0]} !== {cyc + 1 == 16, cyc + 1 >= 16})
        $display("FAIL sparse_latency edge %0d: got %b want %b", cyc + 1,
                 {rise[0], sen_out[0]}, {cyc + 1 == 16, cyc + 1 >= 16});
      else n_pass++;
    end
    tick = 1'b1;
    sen_in[0] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [N_CH-1:0] e_r, e_o;
    sen_in[1] = 1'b1;
    repeat (10) @(negedge clk);
    sen_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (sen_out[1] !== 1'b1) $display("FAIL pre_reset_level: got %b want 1", sen_out[1]);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (act !== '0) $display("FAIL async_reset: got %h want 0", act);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      e_r = (k == 7) ? 4'b0011 : 4'b0000;
      e_o = (k >= 7) ? 4'b0011 : 4'b0000;
      n_checks++;
      if (act !== exp_v) $display("FAIL reset_exit_model edge %0d: got %h want %h", k, act, exp_v);
      else n_pass++;
      n_checks++;
      if ({rise, sen_out, fall} !== {e_r, e_o, 4'b0000})
        $display("FAIL reset_exit_latency edge %0d: got %h want %h", k, {rise, sen_out, fall}, {e_r, e_o, 4'b0000});
      else n_pass++;
    end
    sen_in = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 7) == 0) sen_in[c] = ~sen_in[c];
      tick = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      n_checks++;
      if (act !== exp_v) $display("FAIL random_model cyc %0d: got %h want %h", cyc, act, exp_v);
      else n_pass++;
    end
    tick = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_toggle();
    test_sparse_tick();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
